mod_counter: RTL
================

// Module: mod_counter
// PURPOSE
//  Parametrised up/down modulo counter. Successor to the fixed 8-bit register+adder counter.
//  Adds synchronous load, enable, a programmable step, a wrap or saturate mode and a modulo limit.
//  Drives a terminal-count pulse and a carry/borrow flag, so instances can be cascaded.
//  Used as the generic count/timebase block in generated designs.
// PARAMETERS
//  WIDTH    8     counter width in bits (1..32)
//  MODULO   256   count range 0..MODULO-1; 2 <= MODULO <= 2**WIDTH
//  RST_VAL  0     value after reset; must be < MODULO
// PORTS
//  clk       in   1      rising-edge clock
//  rst_n     in   1      asynchronous active-low reset
//  en        in   1      count enable; step applied when 1
//  up        in   1      1 = count up, 0 = count down
//  step      in   WIDTH  increment/decrement amount; treated as step mod MODULO
//  sat       in   1      1 = saturate at end stop, 0 = wrap modulo MODULO
//  load      in   1      synchronous load of load_val
//  load_val  in   WIDTH  value to load; values >= MODULO are clamped to MODULO-1
//  count     out  WIDTH  current count (registered)
//  tc        out  1      registered one-cycle pulse: an end stop was reached or crossed this step
//  wrapped   out  1      registered one-cycle pulse: the count wrapped (carry up or borrow down)
//  at_max    out  1      combinational: count == MODULO-1
//  at_min    out  1      combinational: count == 0
// BEHAVIOUR
//  - Reset (rst_n=0, async): count=RST_VAL, tc=0, wrapped=0. This holds until the first
//    clk edge after rst_n deasserts. Reset mid-count abandons the count immediately.
//  - Priority per clk edge: load > en > hold.
//  - load=1: count<=min(load_val,MODULO-1); tc<=0; wrapped<=0. Any en on that cycle is ignored.
//  - en=1, load=0, up=1:
//    - Compute sum = count + step_m using WIDTH+1 bits, where step_m = step mod MODULO.
//    - If sum <= MODULO-1: count<=sum, tc<=0, wrapped<=0.
//    - If sum > MODULO-1 and sat=0: count<=sum-MODULO, tc<=1, wrapped<=1.
//    - If sum > MODULO-1 and sat=1: count<=MODULO-1, tc<=1, wrapped<=0.
//    - Landing exactly on MODULO-1 sets tc<=1 and wrapped<=0.
//  - en=1, load=0, up=0: mirror image of the up case.
//    - If count >= step_m: count<=count-step_m.
//    - Otherwise, sat=0: count<=count+MODULO-step_m, tc<=1, wrapped<=1.
//    - Otherwise, sat=1: count<=0, tc<=1, wrapped<=0.
//    - Landing exactly on 0 sets tc<=1.
//  - step_m==0 with en=1: count holds; tc<=1 only if count is already at the end stop
//    in the count direction. Otherwise tc<=0.
//  - en=0, load=0: count holds; tc<=0; wrapped<=0.
//  - Saturated and en=1 pushing further into the end stop: count holds, tc<=1 each cycle,
//    wrapped<=0.
//  - Latency: count, tc and wrapped update on the edge where the step is applied.
//    at_max and at_min follow count combinationally.
//  - No intermediate result may exceed WIDTH+1 bits. MODULO==2**WIDTH must work
//    (natural wrap).
// STRUCTURE
//  - Shared package: none needed. Keep MODULO-1 and the WIDTH+1 sum width as localparams.
//  - Sub-module mod_step_adder (combinational). Inputs a, b, dir, sat.
//    Outputs next, tc_n and wrap_n. Instantiated once.
//  - Top level holds the count, tc and wrapped registers and the load/en priority mux.
// TESTING
//  1. Reset: rst_n=0 mid-count (count=0x37) with no clk edge -> count=RST_VAL at once,
//     tc=0, wrapped=0.
//  2. WIDTH=8, MODULO=10, up, step=1, sat=0, 12 enabled edges from 0:
//     - count runs 1..9,0,1,2
//     - tc=1 on the edges producing 9 and 0
//     - wrapped=1 only on 9->0.
//  3. MODULO=10, count=8, up, step=3, sat=0 -> count=1, tc=1, wrapped=1.
//     Same with sat=1 -> count=9, tc=1, wrapped=0.
//     A further enabled edge -> count=9, tc=1.
//  4. Down, MODULO=10, count=1, step=2: sat=0 -> count=9, wrapped=1;
//     sat=1 -> count=0, tc=1.
//  5. load=1, en=1, load_val=0xFF, MODULO=10 -> count=9, tc=0 (load wins, clamped).
//  6. WIDTH=4, MODULO=16, up, step=1, 16 enabled edges from 0xF: count cycles 0..F,
//     wrapped=1 exactly once. en=0 cycles interleaved -> count holds, tc=0.

Source files
------------

// File: rtl/mod_counter_pkg.sv
// Shared types for the modulo counter slice.
// The count direction is named so the adder reads in the design's own terms.
package mod_counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage

// File: rtl/mod_counter_if.sv
// Control and status bundle of the modulo counter.
// The master drives the controls; the slave is the counter itself.
interface mod_counter_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             up;
  logic [WIDTH-1:0] step;
  logic             sat;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrapped;
  logic             at_max;
  logic             at_min;

  modport master (
    output en, up, step, sat, load, load_val,
    input  count, tc, wrapped, at_max, at_min
  );

  modport slave (
    input  en, up, step, sat, load, load_val,
    output count, tc, wrapped, at_max, at_min
  );
endinterface

// File: rtl/mod_step_adder.sv
// Combinational step of the modulo counter: applies step mod MODULO in either direction
// and resolves the end stop by wrapping or saturating.
module mod_step_adder
  import mod_counter_pkg::*;
#(
  parameter int     WIDTH  = 8,
  parameter longint MODULO = 256
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  dir_e             dir,
  input  logic             sat,
  output logic [WIDTH-1:0] next,
  output logic             tc_n,
  output logic             wrap_n
);
  localparam int               SUM_W = WIDTH + 1;
  localparam logic [SUM_W-1:0] MOD_V = SUM_W'(MODULO);
  localparam logic [SUM_W-1:0] MAX_V = SUM_W'(MODULO - 1);

  logic [SUM_W-1:0] a_w;
  logic [SUM_W-1:0] b_m;
  logic [SUM_W-1:0] res;
  logic             unused_msb;

  // Every result is below MODULO, so the extra sum bit is always zero at the output.
  always_comb begin
    a_w    = {1'b0, a};
    b_m    = {1'b0, b} % MOD_V;
    res    = a_w;
    tc_n   = 1'b0;
    wrap_n = 1'b0;
    if (dir == DIR_UP) begin
      res = a_w + b_m;
      if (res > MAX_V) begin
        tc_n = 1'b1;
        if (sat) begin
          res = MAX_V;
        end else begin
          res    = res - MOD_V;
          wrap_n = 1'b1;
        end
      end else begin
        tc_n = (res == MAX_V);
      end
    end else begin
      if (a_w >= b_m) begin
        res  = a_w - b_m;
        tc_n = (res == '0);
      end else begin
        tc_n = 1'b1;
        if (sat) begin
          res = '0;
        end else begin
          res    = a_w + (MOD_V - b_m);
          wrap_n = 1'b1;
        end
      end
    end
    {unused_msb, next} = res;
  end
endmodule

// File: rtl/mod_counter.sv
// Parametrised up/down modulo counter with load, enable, programmable step,
// wrap/saturate mode and cascadable terminal-count / carry-borrow pulses.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int     WIDTH   = 8,
  parameter longint MODULO  = 256,
  parameter longint RST_VAL = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  mod_counter_if.slave  bus
);
  localparam int               SUM_W = WIDTH + 1;
  localparam logic [SUM_W-1:0] MAX_V = SUM_W'(MODULO - 1);
  localparam logic [WIDTH-1:0] MAX_W = MAX_V[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_W = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] count_q;
  logic             tc_q;
  logic             wrapped_q;
  logic [WIDTH-1:0] next_count;
  logic             next_tc;
  logic             next_wrap;
  logic [WIDTH-1:0] load_clamped;

  mod_step_adder #(
    .WIDTH  (WIDTH),
    .MODULO (MODULO)
  ) u_adder (
    .a      (count_q),
    .b      (bus.step),
    .dir    (dir_e'(bus.up)),
    .sat    (bus.sat),
    .next   (next_count),
    .tc_n   (next_tc),
    .wrap_n (next_wrap)
  );

  assign load_clamped = ({1'b0, bus.load_val} > MAX_V) ? MAX_W : bus.load_val;

  // Load beats enable; an idle cycle holds the count and clears both pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= RST_W;
      tc_q      <= 1'b0;
      wrapped_q <= 1'b0;
    end else if (bus.load) begin
      count_q   <= load_clamped;
      tc_q      <= 1'b0;
      wrapped_q <= 1'b0;
    end else if (bus.en) begin
      count_q   <= next_count;
      tc_q      <= next_tc;
      wrapped_q <= next_wrap;
    end else begin
      tc_q      <= 1'b0;
      wrapped_q <= 1'b0;
    end
  end

  assign bus.count   = count_q;
  assign bus.tc      = tc_q;
  assign bus.wrapped = wrapped_q;
  assign bus.at_max  = (count_q == MAX_W);
  assign bus.at_min  = (count_q == '0);
endmodule
